// File: rtl/cbrt_pkg.sv
// Shared widths, defaults and FSM encoding for the cube-root feed controller.
package cbrt_pkg;

  localparam int unsigned CBRT_A_W         = 8;
  localparam int unsigned CBRT_Y_W         = 4;
  localparam int unsigned CBRT_DEPTH       = 4;
  localparam int unsigned CBRT_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } cbrt_state_e;

endpackage

// File: rtl/cbrt_feed_ctrl_if.sv
// Operand stream, result stream and core handshake of cbrt_feed_ctrl.
// master = surroundings (producer, consumer, core); slave = the controller.
interface cbrt_feed_ctrl_if
  import cbrt_pkg::*;
#(
  parameter int unsigned A_W = CBRT_A_W,
  parameter int unsigned Y_W = CBRT_Y_W
);

  logic [A_W-1:0] op_data_i;
  logic           op_valid_i;
  logic           op_ready_o;
  logic [Y_W-1:0] res_data_o;
  logic [A_W-1:0] res_op_o;
  logic           res_valid_o;
  logic           res_ready_i;
  logic [A_W-1:0] core_a_o;
  logic           core_start_o;
  logic [Y_W-1:0] core_y_i;
  logic           core_busy_i;
  logic           err_o;

  modport master (
    output op_data_i, op_valid_i, res_ready_i, core_y_i, core_busy_i,
    input  op_ready_o, res_data_o, res_op_o, res_valid_o, core_a_o, core_start_o, err_o
  );

  modport slave (
    input  op_data_i, op_valid_i, res_ready_i, core_y_i, core_busy_i,
    output op_ready_o, res_data_o, res_op_o, res_valid_o, core_a_o, core_start_o, err_o
  );

endinterface

// File: rtl/cbrt_op_fifo.sv
// Synchronous operand FIFO with full/empty flags and asynchronous active-high reset.
module cbrt_op_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          wr_ok, rd_ok;

  assign full_o    = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/cbrt_feed_ctrl.sv
// Stream front end for the iterative cube-root core: queues operands, launches one at a
// time and holds each result in a valid/ready slot. CBRT_FEED_TIMEOUT_EN adds a watchdog.
module cbrt_feed_ctrl
  import cbrt_pkg::*;
#(
  parameter int unsigned A_W         = CBRT_A_W,
  parameter int unsigned Y_W         = CBRT_Y_W,
  parameter int unsigned DEPTH       = CBRT_DEPTH,
  parameter int unsigned TIMEOUT_CYC = CBRT_TIMEOUT_CYC
) (
  input logic             clk_i,
  input logic             rst_i,
  cbrt_feed_ctrl_if.slave bus
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 8-bit watchdog");
  end

  cbrt_state_e    state_q, state_d;
  logic [A_W-1:0] core_a_q, core_a_d;
  logic [A_W-1:0] shadow_q, shadow_d;
  logic [Y_W-1:0] res_data_q, res_data_d;
  logic [A_W-1:0] res_op_q, res_op_d;
  logic           res_valid_q, res_valid_d;
  logic           pop, start, fifo_full, fifo_empty, tmo_hit;
  logic [A_W-1:0] fifo_head;

  cbrt_op_fifo #(
    .W     (A_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (bus.op_valid_i && !fifo_full),
    .wr_data_i (bus.op_data_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    core_a_d    = core_a_q;
    shadow_d    = shadow_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_valid_d = res_valid_q && !bus.res_ready_i;
    pop         = 1'b0;
    start       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Uses the registered valid, so a slot draining this cycle still blocks the pop.
        if (!fifo_empty && !res_valid_q) begin
          pop      = 1'b1;
          core_a_d = fifo_head;
          shadow_d = fifo_head;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        start   = 1'b1;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (tmo_hit)               state_d = StIdle;
        else if (bus.core_busy_i)  state_d = StWaitDone;
      end
      StWaitDone: begin
        if (tmo_hit) begin
          state_d = StIdle;
        end else if (!bus.core_busy_i) begin
          res_data_d  = bus.core_y_i;
          res_op_d    = shadow_q;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      core_a_q    <= '0;
      shadow_q    <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_a_q    <= core_a_d;
      shadow_q    <= shadow_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef CBRT_FEED_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;

  // One count spans both wait states; cleared while the start pulse is out.
  assign tmo_hit = ((state_q == StWaitBusy) || (state_q == StWaitDone)) &&
                   (tmo_cnt_q == TmoLast);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q || tmo_hit;
    if (state_q == StLaunch) begin
      tmo_cnt_d = '0;
    end else if ((state_q == StWaitBusy) || (state_q == StWaitDone)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  assign bus.op_ready_o   = !fifo_full;
  assign bus.res_data_o   = res_data_q;
  assign bus.res_op_o     = res_op_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.core_a_o     = core_a_q;
  assign bus.core_start_o = start;

endmodule

// File: doc/cbrt_feed_ctrl.md
Name: cbrt_feed_ctrl

Overview:
- Stream-side front end for the iterative 8-bit cube-root core (`rt3`: start/busy handshake, 4-bit result).
- Buffers incoming operands in a small FIFO and launches the core one operand at a time.
- Captures each result when busy falls and presents it downstream with valid/ready.
- Sits between the operand producer and the result consumer; the core instance lives outside this block.

Parameters:
- A_W, 8, operand width (matches core a_i).
- Y_W, 4, result width (matches core y_bo).
- DEPTH, 4, operand FIFO entries (power of two, >=2).
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- op_data_i  in  A_W  operand from producer.
- op_valid_i  in  1  operand valid.
- op_ready_o  out  1  FIFO not full.
- res_data_o  out  Y_W  captured result.
- res_op_o  out  A_W  operand that produced res_data_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts.
- core_a_o  out  A_W  operand driven to core a_i.
- core_start_o  out  1  start pulse to core.
- core_y_i  in  Y_W  core result.
- core_busy_i  in  1  core busy.
- err_o  out  1  sticky watchdog error (constant 0 without the optional feature).

Behaviour:
- Reset, asynchronous, takes effect immediately: FIFO empty; op_ready_o=1; res_valid_o=0; res_data_o=0; res_op_o=0; core_start_o=0; core_a_o=0; err_o=0; FSM=IDLE.
- Reset mid-operation discards all queued and in-flight operands. The core is reset by the same rst_i externally.
- FIFO write: op_valid_i && op_ready_o.
- FIFO read: the IDLE->LAUNCH transition only.
- Simultaneous read and write when full is not allowed, because op_ready_o=0 when full.
- Simultaneous read and write when non-full keeps the count unchanged.
- Pointers wrap modulo DEPTH. Count is one bit wider than the pointers.
- FSM states:
  - IDLE: when FIFO non-empty and res_valid_o=0, pop the head into core_a_o and the operand shadow register, then go to LAUNCH.
  - LAUNCH: core_start_o=1 for exactly this one cycle; core_a_o stays stable. Next state WAIT_BUSY.
  - WAIT_BUSY: stay until core_busy_i=1, then go to WAIT_DONE. The core may take any number of cycles to raise busy.
  - WAIT_DONE: on core_busy_i=0, register res_data_o<=core_y_i and res_op_o<=shadow, set res_valid_o=1, go to IDLE.
- core_a_o holds its value from the pop through WAIT_DONE. It is not cleared afterwards.
- Output slot:
  - res_valid_o stays high until res_ready_i=1. data and op are held stable while valid.
  - A new launch is blocked while res_valid_o=1, so there is at most one result outstanding.
  - A pop in the same cycle the slot drains is not allowed; the launch occurs the following cycle.
- Latency, empty FIFO, free slot, operand accepted at edge N:
  - pop at N+1;
  - start at N+2;
  - result valid one cycle after busy falls.
- Throughput: one operand per core latency plus 3 cycles.
- Results leave in operand order.

Optional Feature:
- Macro: CBRT_FEED_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT_CYC in either state sets err_o (sticky until reset).
  - The FSM then returns to IDLE without producing a result, and the operand is dropped.
- Not defined: no counter; the FSM waits indefinitely; err_o is tied 0.

Decomposition:
- Shared package `cbrt_pkg`:
  - widths A_W and Y_W;
  - FSM state encoding (IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3);
  - default TIMEOUT_CYC.
- One natural sub-module: `cbrt_op_fifo`, a synchronous FIFO with full/empty flags and asynchronous reset. The FSM and output slot stay in the top.

Test Plan:
- Bench connects the block to an `rt3` instance.
- Single operand 63 after reset:
  - start pulses exactly 1 cycle;
  - res_valid_o rises after busy falls;
  - res_data_o=3, res_op_o=63.
- Burst of 4 operands back-to-back (0, 64, 125, 255) with res_ready_i=1:
  - op_ready_o drops at full;
  - results appear in order: 0, 4, 5, 6.
- Output backpressure:
  - Hold res_ready_i=0 for 50 cycles after the first result.
  - res_data_o stays 4 and stable; no second start is issued.
  - Release res_ready_i: the next launch starts one cycle later.
- Reset pulse while in WAIT_DONE with 2 operands queued:
  - all outputs return to reset values immediately;
  - FIFO empty; no stale result appears afterwards.
- With CBRT_FEED_TIMEOUT_EN, core_busy_i forced to 1:
  - err_o rises TIMEOUT_CYC cycles after entering WAIT_BUSY/WAIT_DONE;
  - FSM returns to IDLE; res_valid_o stays 0.
- FIFO wrap:
  - Stream 10 operands (1..10) with res_ready_i=1.
  - Results: 1,1,1,1,1,1,1,2,2,2; the pointer wraps twice without loss.
